mul_result_deser: RTL and testbench

- Receive end of the shared complex-multiplier path: the time-multiplexed multiplier emits one complex product per fast-clock beat, and this block collects them.
- Collects P_LANES consecutive products into a parallel result bundle and presents it atomically with a one-cycle valid pulse.
- Sits between the shared multiplier output and the butterfly stage's slow-rate registers.
- Detects framing errors: orphan beats, restarts mid-frame, and stalls when the optional feature is enabled.

---
 rtl/mul_deser_pkg.sv | 21 ++
 rtl/mul_deser_lane_buf.sv | 37 +++
 rtl/mul_result_deser.sv | 160 ++++++++++++++++
 tb/tb_mul_result_deser.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_deser_pkg.sv
// Shared definitions for the complex-multiplier result deserializer.
//   calc_w  : width of one product part (real or imag) from operand width
//             and fractional bits.
//   state_t : FSM encoding (IDLE = waiting for lane 0, COLLECT = mid-frame).
//   lane_lo : low bit offset of a lane inside the flat frame vector.
package mul_deser_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  function automatic int calc_w(input int input_width, input int point_position);
    return 2 * input_width - point_position + 1;
  endfunction

  function automatic int lane_lo(input int lane, input int w);
    return lane * 2 * w;
  endfunction

endpackage

// File: rtl/mul_deser_lane_buf.sv
// Shadow buffer holding one partially assembled frame.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset (clears all lanes)
//   wr_en      : write wr_data into lane wr_lane on this edge
//   wr_lane    : lane index to write
//   wr_data    : {real, imag} of one product
//   data       : all lanes flattened, lane k at [lane_lo(k)+2W-1 : lane_lo(k)]
module mul_deser_lane_buf
  import mul_deser_pkg::*;
#(
  parameter int P_LANES = 4,
  parameter int W       = 11,
  parameter int LW      = $clog2(P_LANES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [LW-1:0]            wr_lane,
  input  logic [2*W-1:0]           wr_data,
  output logic [P_LANES*2*W-1:0]   data
);

  logic [2*W-1:0] lanes [P_LANES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < P_LANES; k++) lanes[k] <= '0;
    end else if (wr_en) begin
      lanes[wr_lane] <= wr_data;
    end
  end

  for (genvar k = 0; k < P_LANES; k++) begin : g_flat
    assign data[lane_lo(k, W) +: 2*W] = lanes[k];
  end

endmodule

// File: rtl/mul_result_deser.sv
// Collects P_LANES consecutive complex products from the time-multiplexed
// multiplier into one parallel frame, presented with a one-cycle o_valid.
// Framing errors (orphan beat, restart mid-frame, optional stall timeout)
// produce a one-cycle o_err.
// Optional feature macro: MUL_DESER_TIMEOUT_EN (mid-frame stall watchdog).
// Ports:
//   CLK     : fast multiplier clock, rising edge
//   RST     : asynchronous active-low reset
//   i_valid : product beat present
//   i_first : beat is lane 0 of a frame (qualified by i_valid)
//   i_real  : real part of product, W bits two's complement
//   i_imag  : imaginary part of product, W bits two's complement
//   o_data  : committed frame, lane k = {real, imag} at [(k+1)*2W-1 : k*2W]
//   o_valid : one-cycle pulse, o_data holds a new frame
//   o_err   : one-cycle framing-error pulse
// Handshake: no backpressure. A beat is consumed on every rising CLK edge
// where i_valid is high; o_valid/o_err are single-cycle pulses the consumer
// must capture in that cycle.
module mul_result_deser
  import mul_deser_pkg::*;
#(
  parameter int P_INPUT_WIDTH    = 8,
  parameter int P_POINT_POSITION = 6,
  parameter int P_LANES          = 4,
  parameter int P_TIMEOUT        = 15
) (
  input  logic                                                         CLK,
  input  logic                                                         RST,
  input  logic                                                         i_valid,
  input  logic                                                         i_first,
  input  logic [calc_w(P_INPUT_WIDTH, P_POINT_POSITION)-1:0]           i_real,
  input  logic [calc_w(P_INPUT_WIDTH, P_POINT_POSITION)-1:0]           i_imag,
  output logic [P_LANES*2*calc_w(P_INPUT_WIDTH, P_POINT_POSITION)-1:0] o_data,
  output logic                                                         o_valid,
  output logic                                                         o_err
);

  localparam int W  = calc_w(P_INPUT_WIDTH, P_POINT_POSITION);
  localparam int DW = P_LANES * 2 * W;
  localparam int LW = $clog2(P_LANES);
  localparam logic [LW-1:0] LAST = LW'(P_LANES - 1);

  state_t          state_q, state_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic            wr_en;
  logic [LW-1:0]   wr_lane;
  logic            commit;
  logic            valid_d, err_d;
  logic            timeout;
  logic [DW-1:0]   buf_data;
  logic [DW-1:0]   commit_data;

  mul_deser_lane_buf #(
    .P_LANES (P_LANES),
    .W       (W),
    .LW      (LW)
  ) u_lane_buf (
    .clk     (CLK),
    .rst_n   (RST),
    .wr_en   (wr_en),
    .wr_lane (wr_lane),
    .wr_data ({i_real, i_imag}),
    .data    (buf_data)
  );

  // The last lane goes straight from the input into o_data, so the commit
  // does not wait for the shadow buffer to capture it.
  assign commit_data = {i_real, i_imag, buf_data[DW-2*W-1:0]};

`ifdef MUL_DESER_TIMEOUT_EN
  localparam int TW = $clog2(P_TIMEOUT + 1);
  logic [TW-1:0] wd_q;

  // Counts consecutive idle cycles inside a frame; cleared by any beat and
  // whenever the FSM sits in IDLE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wd_q <= '0;
    end else if (state_q == IDLE || i_valid || timeout) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 1'b1;
    end
  end

  // Fires on the P_TIMEOUT-th consecutive idle cycle.
  assign timeout = (state_q == COLLECT) && !i_valid && (wd_q == TW'(P_TIMEOUT - 1));
`else
  // No watchdog: COLLECT waits indefinitely for the next beat.
  assign timeout = (P_TIMEOUT < 0);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_lane = cnt_q;
    commit  = 1'b0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (i_first) begin
            wr_en   = 1'b1;
            wr_lane = '0;
            cnt_d   = LW'(1);
            state_d = COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (i_valid) begin
          if (i_first) begin
            // Restart: drop the partial frame and begin a new one.
            err_d   = 1'b1;
            wr_en   = 1'b1;
            wr_lane = '0;
            cnt_d   = LW'(1);
          end else if (cnt_q == LAST) begin
            commit  = 1'b1;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_valid <= valid_d;
      o_err   <= err_d;
      if (commit) o_data <= commit_data;
    end
  end

endmodule

// File: tb/tb_mul_result_deser.sv
module tb_mul_result_deser;

  localparam int W  = 2 * 8 - 6 + 1;
  localparam int NL = 4;
  localparam int DW = NL * 2 * W;

  logic          CLK;
  logic          RST;
  logic          i_valid;
  logic          i_first;
  logic [W-1:0]  i_real;
  logic [W-1:0]  i_imag;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_frame;
  logic [DW-1:0] exp_frame;

  mul_result_deser #(
    .P_INPUT_WIDTH    (8),
    .P_POINT_POSITION (6),
    .P_LANES          (NL),
    .P_TIMEOUT        (15)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .i_valid (i_valid),
    .i_first (i_first),
    .i_real  (i_real),
    .i_imag  (i_imag),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_err   (o_err)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- model ----------------
  // Frame of lanes k = 0..3 carrying (base+k, -(base+k)).
  function automatic logic [DW-1:0] make_frame(input int base);
    logic [DW-1:0] f;
    logic [W-1:0]  re, im;
    f = '0;
    for (int k = 0; k < NL; k++) begin
      re = W'(base + k);
      im = W'(-(base + k));
      f[k*2*W +: 2*W] = {re, im};
    end
    return f;
  endfunction

  // ---------------- drivers ----------------
  // Present one beat from the falling edge, returning 1 time unit after the
  // sampling edge with i_valid dropped again.
  task automatic drive(input logic first, input int re, input int im);
    @(negedge CLK);
    i_valid = 1'b1;
    i_first = first;
    i_real  = W'(re);
    i_imag  = W'(im);
    @(posedge CLK);
    #1;
    i_valid = 1'b0;
    i_first = 1'b0;
  endtask

  task automatic idle();
    @(negedge CLK);
    i_valid = 1'b0;
    i_first = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  // Sends beat k (0-based) of the frame starting at base and checks that
  // no pulse appears unless it is the last lane, where the frame must commit.
  task automatic send_lane(input int base, input int k, input string tag);
    drive(k == 0, base + k, -(base + k));
    if (k < NL - 1) begin
      n_checks++;
      if (o_valid !== 1'b0 || o_err !== 1'b0) begin
        n_fail++;
        $display("FAIL %s lane%0d pulses: valid=%b err=%b required 0/0", tag, k, o_valid, o_err);
      end
    end else begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s scoreboard empty at commit", tag);
      end else begin
        exp_frame = exp_q.pop_front();
        if (o_valid !== 1'b1 || o_err !== 1'b0 || o_data !== exp_frame) begin
          n_fail++;
          $display("FAIL %s commit: valid=%b err=%b data=%h required 1/0 %h",
                   tag, o_valid, o_err, o_data, exp_frame);
        end
        last_frame = exp_frame;
      end
    end
  endtask

  task automatic check_quiet(input string tag);
    n_checks++;
    if (o_valid !== 1'b0 || o_err !== 1'b0 || o_data !== last_frame) begin
      n_fail++;
      $display("FAIL %s quiet: valid=%b err=%b data=%h required 0/0 %h",
               tag, o_valid, o_err, o_data, last_frame);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b0; i_valid = 1'b0; i_first = 1'b0; i_real = '0; i_imag = '0;
    last_frame = '0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if (o_data !== '0 || o_valid !== 1'b0 || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset outputs: data=%h valid=%b err=%b required 0", o_data, o_valid, o_err);
    end
    @(negedge CLK);
    RST = 1'b1;
    idle();
    check_quiet("reset_release");
  endtask

  task automatic test_clean_frame();
    exp_q.push_back(make_frame(1));
    for (int k = 0; k < NL; k++) send_lane(1, k, "clean");
    idle();
    check_quiet("clean_after");
  endtask

  task automatic test_gapped();
    exp_q.push_back(make_frame(1));
    send_lane(1, 0, "gapped");
    send_lane(1, 1, "gapped");
    idle();
    check_quiet("gapped_gap1");
    idle();
    check_quiet("gapped_gap2");
    send_lane(1, 2, "gapped");
    send_lane(1, 3, "gapped");
    idle();
    check_quiet("gapped_after");
  endtask

  task automatic test_orphan();
    drive(1'b0, 'h155, 'h155);
    n_checks++;
    if (o_err !== 1'b1 || o_valid !== 1'b0 || o_data !== last_frame) begin
      n_fail++;
      $display("FAIL orphan: err=%b valid=%b data=%h required 1/0 %h", o_err, o_valid, o_data, last_frame);
    end
    idle();
    check_quiet("orphan_after");
  endtask

  task automatic test_restart();
    send_lane(30, 0, "restart_partial");
    send_lane(30, 1, "restart_partial");
    exp_q.push_back(make_frame(5));
    drive(1'b1, 5, -5);
    n_checks++;
    if (o_err !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL restart err: err=%b valid=%b required 1/0", o_err, o_valid);
    end
    for (int k = 1; k < NL; k++) send_lane(5, k, "restart");
    idle();
    check_quiet("restart_after");
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(make_frame(9));
    exp_q.push_back(make_frame(13));
    for (int k = 0; k < NL; k++) send_lane(9, k, "b2b_a");
    for (int k = 0; k < NL; k++) send_lane(13, k, "b2b_b");
    // third frame interrupted by reset
    send_lane(40, 0, "b2b_c");
    send_lane(40, 1, "b2b_c");
    #2;
    RST = 1'b0;
    #1;
    n_checks++;
    if (o_data !== '0 || o_valid !== 1'b0 || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe reset: data=%h valid=%b err=%b required 0", o_data, o_valid, o_err);
    end
    last_frame = '0;
    @(negedge CLK);
    RST = 1'b1;
    idle();
    exp_q.push_back(make_frame(17));
    for (int k = 0; k < NL; k++) send_lane(17, k, "post_reset");
    idle();
    check_quiet("post_reset_after");
  endtask

`ifdef MUL_DESER_TIMEOUT_EN
  task automatic test_timeout();
    send_lane(50, 0, "timeout");
    for (int i = 0; i < 14; i++) idle();
    check_quiet("timeout_before");
    idle();
    n_checks++;
    if (o_err !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout err: err=%b valid=%b required 1/0", o_err, o_valid);
    end
    drive(1'b0, 51, -51);
    n_checks++;
    if (o_err !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout idle orphan: err=%b valid=%b required 1/0", o_err, o_valid);
    end
    idle();
    check_quiet("timeout_after");
  endtask
`else
  task automatic test_no_timeout();
    exp_q.push_back(make_frame(21));
    send_lane(21, 0, "long_gap");
    for (int i = 0; i < 20 + $urandom_range(0, 10); i++) idle();
    check_quiet("long_gap_idle");
    for (int k = 1; k < NL; k++) send_lane(21, k, "long_gap");
    idle();
    check_quiet("long_gap_after");
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_clean_frame();
    test_gapped();
    test_orphan();
    test_restart();
    test_back_to_back();
`ifdef MUL_DESER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard leftover: %0d entries required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
